// File: rtl/idli_serial_decode_m.sv
// Serial instruction front-end: deserialises SLICE_W-bit slices into
// word/imm, expands LD/ST ranges (IDLI_SERIAL_DECODE_RANGE_EN).
module idli_serial_decode_m #(
  parameter int SLICE_W = 4,
  parameter int REG_W   = 4
) (
  input  logic               i_sd_gck,
  input  logic               i_sd_rst,
  input  logic               i_sd_redirect,
  input  logic [SLICE_W-1:0] i_sd_enc,
  input  logic               i_sd_enc_vld,
  output logic               o_sd_enc_rdy,
  output logic               o_sd_op_vld,
  input  logic               i_sd_op_rdy,
  output logic [15:0]        o_sd_op_word,
  output logic [15:0]        o_sd_op_imm,
  output logic               o_sd_op_imm_vld,
  output logic [REG_W-1:0]   o_sd_op_reg,
  output logic               o_sd_op_last
);

  localparam int N     = 16 / SLICE_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  generate
    if (!(SLICE_W == 1 || SLICE_W == 2 || SLICE_W == 4 ||
          SLICE_W == 8 || SLICE_W == 16)) begin : g_bad_w
      $error("idli_serial_decode_m: illegal SLICE_W");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_WORD,
    S_IMM,
    S_ISSUE,
    S_EXPAND
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      sr_q;
  logic [15:0]      word_q;
  logic [15:0]      imm_q;
  logic             imm_vld_q;

  logic             acc;
  logic             done;
  logic [3:0]       base;
  logic [15:0]      asm_w;
  logic             asm_range;
  logic             need_imm;
  logic [REG_W-1:0] r_reg;

  assign acc  = i_sd_enc_vld & o_sd_enc_rdy;
  assign done = acc & (cnt_q == CNT_W'(N - 1));

  // Slices land in place; the final slice completes the word in asm_w
  always_comb begin
    asm_w = sr_q;
    base  = 4'((N - 1 - int'(cnt_q)) * SLICE_W);
    asm_w[base +: SLICE_W] = i_sd_enc;
  end

  assign asm_range = (asm_w[15:13] == 3'b100);
  assign need_imm  = !asm_range && (asm_w[3:0] == 4'hF);
  assign r_reg     = REG_W'(word_q[11:8]);

`ifdef IDLI_SERIAL_DECODE_RANGE_EN
  logic [REG_W-1:0] nxt_q;
  logic [REG_W-1:0] s_reg;
  logic             is_range;

  assign s_reg    = REG_W'(word_q[7:4]);
  assign is_range = (word_q[15:13] == 3'b100);
`endif

  always_ff @(posedge i_sd_gck) begin
    if (i_sd_rst || i_sd_redirect) begin
      state_q   <= S_WORD;
      cnt_q     <= '0;
      sr_q      <= '0;
      word_q    <= '0;
      imm_q     <= '0;
      imm_vld_q <= 1'b0;
`ifdef IDLI_SERIAL_DECODE_RANGE_EN
      nxt_q     <= '0;
`endif
    end else begin
      if (acc) begin
        sr_q  <= asm_w;
        cnt_q <= done ? '0 : cnt_q + CNT_W'(1);
      end
      unique case (state_q)
        S_WORD: begin
          if (done) begin
            word_q    <= asm_w;
            imm_q     <= '0;
            imm_vld_q <= need_imm;
            state_q   <= need_imm ? S_IMM : S_ISSUE;
          end
        end
        S_IMM: begin
          if (done) begin
            imm_q   <= asm_w;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (i_sd_op_rdy) begin
`ifdef IDLI_SERIAL_DECODE_RANGE_EN
            if (is_range && (r_reg != s_reg)) begin
              nxt_q   <= r_reg + REG_W'(1);
              state_q <= S_EXPAND;
            end else begin
              state_q <= S_WORD;
            end
`else
            state_q <= S_WORD;
`endif
          end
        end
`ifdef IDLI_SERIAL_DECODE_RANGE_EN
        S_EXPAND: begin
          if (i_sd_op_rdy) begin
            if (nxt_q == s_reg) begin
              state_q <= S_WORD;
            end else begin
              nxt_q <= nxt_q + REG_W'(1);
            end
          end
        end
`endif
        default: state_q <= S_WORD;
      endcase
    end
  end

  assign o_sd_enc_rdy    = (state_q == S_WORD) ||
                           (state_q == S_IMM);
  assign o_sd_op_vld     = (state_q == S_ISSUE) ||
                           (state_q == S_EXPAND);
  assign o_sd_op_word    = word_q;
  assign o_sd_op_imm     = imm_q;
  assign o_sd_op_imm_vld = imm_vld_q;

  always_comb begin
    o_sd_op_reg  = r_reg;
    o_sd_op_last = 1'b0;
`ifdef IDLI_SERIAL_DECODE_RANGE_EN
    if (state_q == S_EXPAND) begin
      o_sd_op_reg  = nxt_q;
      o_sd_op_last = (nxt_q == s_reg);
    end else if (state_q == S_ISSUE) begin
      o_sd_op_last = !is_range || (r_reg == s_reg);
    end
`else
    if (state_q == S_ISSUE) begin
      o_sd_op_last = 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_idli_serial_decode_m.sv
// Directed bench for idli_serial_decode_m at SLICE_W 4, 1 and 16.
// Range expectations follow IDLI_SERIAL_DECODE_RANGE_EN.
module tb_idli_serial_decode_m;

  logic clk;
  logic rst;
  logic redirect;
  logic red0;

  logic [3:0]  enc4;
  logic        vld4, rdy4, ov4, ordy4, iv4, l4;
  logic [15:0] w4, i4;
  logic [3:0]  r4;

  logic [0:0]  enc1;
  logic        vld1, rdy1, ov1, ordy1, iv1, l1;
  logic [15:0] w1, i1;
  logic [3:0]  r1;

  logic [15:0] enc16;
  logic        vld16, rdy16, ov16, ordy16, iv16, l16;
  logic [15:0] w16, i16;
  logic [3:0]  r16;

  int checks;
  int failures;

  idli_serial_decode_m #(.SLICE_W(4)) u_dut4 (
    .i_sd_gck(clk), .i_sd_rst(rst),
    .i_sd_redirect(redirect),
    .i_sd_enc(enc4), .i_sd_enc_vld(vld4),
    .o_sd_enc_rdy(rdy4), .o_sd_op_vld(ov4),
    .i_sd_op_rdy(ordy4), .o_sd_op_word(w4),
    .o_sd_op_imm(i4), .o_sd_op_imm_vld(iv4),
    .o_sd_op_reg(r4), .o_sd_op_last(l4)
  );

  idli_serial_decode_m #(.SLICE_W(1)) u_dut1 (
    .i_sd_gck(clk), .i_sd_rst(rst),
    .i_sd_redirect(red0),
    .i_sd_enc(enc1), .i_sd_enc_vld(vld1),
    .o_sd_enc_rdy(rdy1), .o_sd_op_vld(ov1),
    .i_sd_op_rdy(ordy1), .o_sd_op_word(w1),
    .o_sd_op_imm(i1), .o_sd_op_imm_vld(iv1),
    .o_sd_op_reg(r1), .o_sd_op_last(l1)
  );

  idli_serial_decode_m #(.SLICE_W(16)) u_dut16 (
    .i_sd_gck(clk), .i_sd_rst(rst),
    .i_sd_redirect(red0),
    .i_sd_enc(enc16), .i_sd_enc_vld(vld16),
    .o_sd_enc_rdy(rdy16), .o_sd_op_vld(ov16),
    .i_sd_op_rdy(ordy16), .o_sd_op_word(w16),
    .o_sd_op_imm(i16), .o_sd_op_imm_vld(iv16),
    .o_sd_op_reg(r16), .o_sd_op_last(l16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic expect_op(input string tag,
                           input logic [15:0] w,
                           input logic [15:0] im,
                           input logic iv,
                           input logic [3:0] r,
                           input logic l);
    check({tag, "_vld"}, 32'(ov4), 32'd1);
    check({tag, "_word"}, 32'(w4), 32'(w));
    check({tag, "_imm"}, 32'(i4), 32'(im));
    check({tag, "_immv"}, 32'(iv4), 32'(iv));
    check({tag, "_reg"}, 32'(r4), 32'(r));
    check({tag, "_last"}, 32'(l4), 32'(l));
    check({tag, "_encrdy"}, 32'(rdy4), 32'd0);
  endtask

  task automatic idle4(input string tag);
    check({tag, "_idle_vld"}, 32'(ov4), 32'd0);
    check({tag, "_idle_rdy"}, 32'(rdy4), 32'd1);
  endtask

  task automatic feed4(input logic [15:0] w);
    for (int i = 0; i < 4; i++) begin
      check("pre_vld", 32'(ov4), 32'd0);
      enc4 = w[15 - 4*i -: 4];
      vld4 = 1'b1;
      @(negedge clk);
    end
    vld4 = 1'b0;
  endtask

  initial begin
    logic [15:0] aw;
    logic [3:0] rg [4];
    checks   = 0;
    failures = 0;
    redirect = 1'b0;
    red0     = 1'b0;
    enc4 = '0;  vld4 = 1'b0;  ordy4 = 1'b1;
    enc1 = '0;  vld1 = 1'b0;  ordy1 = 1'b1;
    enc16 = '0; vld16 = 1'b0; ordy16 = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("rst_rdy", 32'(rdy4), 32'd1);
    check("rst_vld", 32'(ov4), 32'd0);
    check("rst_word", 32'(w4), 32'd0);
    check("rst_imm", 32'(i4), 32'd0);
    check("rst_immv", 32'(iv4), 32'd0);
    check("rst_reg", 32'(r4), 32'd0);
    check("rst_last", 32'(l4), 32'd0);

    // plain op
    feed4(16'h1234);
    expect_op("t1", 16'h1234, 16'h0, 1'b0, 4'h2, 1'b1);
    @(negedge clk);
    idle4("t1");

    // op with immediate
    feed4(16'h200F);
    feed4(16'hBEEF);
    expect_op("t2", 16'h200F, 16'hBEEF, 1'b1, 4'h0, 1'b1);
    @(negedge clk);
    idle4("t2");

    // wrapping range, low nibble F takes no immediate
    feed4(16'h8E1F);
`ifdef IDLI_SERIAL_DECODE_RANGE_EN
    rg[0] = 4'hE; rg[1] = 4'hF; rg[2] = 4'h0; rg[3] = 4'h1;
    for (int k = 0; k < 4; k++) begin
      expect_op("t3", 16'h8E1F, 16'h0, 1'b0, rg[k], k == 3);
      @(negedge clk);
    end
`else
    expect_op("t3", 16'h8E1F, 16'h0, 1'b0, 4'hE, 1'b1);
    @(negedge clk);
`endif
    idle4("t3");

    // range with back-pressure
    feed4(16'h9253);
`ifdef IDLI_SERIAL_DECODE_RANGE_EN
    expect_op("t4a", 16'h9253, 16'h0, 1'b0, 4'h2, 1'b0);
    @(negedge clk);
    ordy4 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      expect_op("t4s", 16'h9253, 16'h0, 1'b0, 4'h3, 1'b0);
      @(negedge clk);
    end
    ordy4 = 1'b1;
    expect_op("t4b", 16'h9253, 16'h0, 1'b0, 4'h3, 1'b0);
    @(negedge clk);
    expect_op("t4c", 16'h9253, 16'h0, 1'b0, 4'h4, 1'b0);
    @(negedge clk);
    expect_op("t4d", 16'h9253, 16'h0, 1'b0, 4'h5, 1'b1);
    @(negedge clk);
`else
    ordy4 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      expect_op("t4s", 16'h9253, 16'h0, 1'b0, 4'h2, 1'b1);
      @(negedge clk);
    end
    ordy4 = 1'b1;
    expect_op("t4b", 16'h9253, 16'h0, 1'b0, 4'h2, 1'b1);
    @(negedge clk);
`endif
    idle4("t4");

    // redirect mid-word, slice in the redirect cycle dropped
    enc4 = 4'hF; vld4 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    redirect = 1'b1; enc4 = 4'h7;
    @(negedge clk);
    redirect = 1'b0; vld4 = 1'b0;
    idle4("t5");
    check("t5_word0", 32'(w4), 32'd0);
    feed4(16'h0001);
    expect_op("t5", 16'h0001, 16'h0, 1'b0, 4'h0, 1'b1);
    @(negedge clk);
    idle4("t5e");

    // gaps between slices
    aw = 16'h3C40;
    for (int i = 0; i < 4; i++) begin
      enc4 = aw[15 - 4*i -: 4];
      vld4 = 1'b1;
      @(negedge clk);
      vld4 = 1'b0;
      if (i < 3) begin
        check("t6_gap_vld", 32'(ov4), 32'd0);
        repeat (2) @(negedge clk);
      end
    end
    expect_op("t6", 16'h3C40, 16'h0, 1'b0, 4'hC, 1'b1);
    @(negedge clk);
    idle4("t6");

    // reset drops a pending op
    ordy4 = 1'b0;
    feed4(16'h1234);
    expect_op("t7", 16'h1234, 16'h0, 1'b0, 4'h2, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ordy4 = 1'b1;
    idle4("t7");
    check("t7_word0", 32'(w4), 32'd0);
    check("t7_reg0", 32'(r4), 32'd0);

    // 1-bit slices
    aw = 16'hA5A5;
    for (int i = 0; i < 16; i++) begin
      check("t8_pre_vld", 32'(ov1), 32'd0);
      enc1 = aw[15 - i];
      vld1 = 1'b1;
      @(negedge clk);
    end
    vld1 = 1'b0;
    check("t8_vld", 32'(ov1), 32'd1);
    check("t8_word", 32'(w1), 32'hA5A5);
    check("t8_reg", 32'(r1), 32'h5);
    check("t8_last", 32'(l1), 32'd1);
    check("t8_immv", 32'(iv1), 32'd0);
    check("t8_encrdy", 32'(rdy1), 32'd0);
    @(negedge clk);
    check("t8_done", 32'(ov1), 32'd0);

    // 16-bit slice
    check("t9_pre_vld", 32'(ov16), 32'd0);
    enc16 = 16'hA5A5;
    vld16 = 1'b1;
    @(negedge clk);
    vld16 = 1'b0;
    check("t9_vld", 32'(ov16), 32'd1);
    check("t9_word", 32'(w16), 32'hA5A5);
    check("t9_reg", 32'(r16), 32'h5);
    check("t9_last", 32'(l16), 32'd1);
    check("t9_imm", 32'(i16), 32'd0);
    check("t9_encrdy", 32'(rdy16), 32'd0);
    @(negedge clk);
    check("t9_done", 32'(ov16), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
